tpu_result_uart_tx: RTL

Readback path for the TPU I/O top. It streams the result buffer out over the UART TX pin, which is the opposite direction to the host-to-board write path.
- On a start pulse it reads N 16-bit FP16 words from a synchronous result RAM.
- It serialises a framed byte stream at 8N1, LSB first.
- It sits between the result memory read port and the board uart_tx pin.

---
 rtl/tpu_result_uart_tx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tpu_result_uart_tx.sv
// Streams the TPU result buffer out of the board as a framed 8N1 UART stream.
// Optional: define TPU_RESULT_TX_CHECKSUM_EN to append an XOR checksum byte.
module tpu_result_uart_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         RESULT_DEPTH = 16,
    parameter int         ADDR_W       = 4,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [15:0]       rd_data,
    output logic              uart_tx,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int AW1   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]  DEPTH   = AW1'(RESULT_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_HDR, S_FETCH, S_CAPTURE,
        S_SEND_HI, S_SEND_LO, S_TAIL, S_FINISH
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W:0]   n_q, idx_q, idx_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_en_q;
    logic [7:0]        lo_q;

    logic              act_q, tx_q;
    logic [8:0]        sh_q;
    logic [3:0]        bit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ser_last;

    logic              ld, ld_data, accept;
    logic [7:0]        ld_byte;

`ifdef TPU_RESULT_TX_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign ser_last = act_q && (cnt_q == CNT_MAX) && (bit_q == 4'd9);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ld      = 1'b0;
        ld_data = 1'b0;
        ld_byte = 8'h00;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    ld      = 1'b1;
                    ld_byte = HEADER_BYTE;
                    state_d = S_SEND_HDR;
                end
            end
            S_SEND_HDR: begin
                if (ser_last) begin
                    if (n_q != '0) begin
                        state_d = S_FETCH;
                    end else begin
`ifdef TPU_RESULT_TX_CHECKSUM_EN
                        ld      = 1'b1;
                        ld_byte = csum_q;
                        state_d = S_TAIL;
`else
                        state_d = S_FINISH;
`endif
                    end
                end
            end
            S_FETCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
                ld      = 1'b1;
                ld_data = 1'b1;
                ld_byte = rd_data[15:8];
                state_d = S_SEND_HI;
            end
            S_SEND_HI: begin
                if (ser_last) begin
                    ld      = 1'b1;
                    ld_data = 1'b1;
                    ld_byte = lo_q;
                    state_d = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (ser_last) begin
                    if (idx_q + 1'b1 == n_q) begin
`ifdef TPU_RESULT_TX_CHECKSUM_EN
                        ld      = 1'b1;
                        ld_byte = csum_q;
                        state_d = S_TAIL;
`else
                        state_d = S_FINISH;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_TAIL:   if (ser_last) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            lo_q      <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rd_en_q <= (state_d == S_FETCH);
            if (state_d == S_FETCH) rd_addr_q <= idx_d[ADDR_W-1:0];
            if (accept) n_q <= (num_words > DEPTH) ? DEPTH : num_words;
            if (state_q == S_CAPTURE) lo_q <= rd_data[7:0];
        end
    end

    // A load on the final stop-bit cycle chains the next start bit with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q <= 1'b0;
            tx_q  <= 1'b1;
            sh_q  <= '1;
            bit_q <= 4'd0;
            cnt_q <= '0;
        end else if (ld) begin
            act_q <= 1'b1;
            tx_q  <= 1'b0;
            sh_q  <= {1'b1, ld_byte};
            bit_q <= 4'd0;
            cnt_q <= '0;
        end else if (act_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                if (bit_q == 4'd9) begin
                    act_q <= 1'b0;
                    tx_q  <= 1'b1;
                end else begin
                    tx_q  <= sh_q[0];
                    sh_q  <= {1'b1, sh_q[8:1]};
                    bit_q <= bit_q + 4'd1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef TPU_RESULT_TX_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            csum_q <= 8'h00;
        end else if (ld && ld_data) begin
            csum_q <= csum_q ^ ld_byte;
        end
    end
`endif

    assign rd_addr = rd_addr_q;
    assign rd_en   = rd_en_q;
    assign uart_tx = tx_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done    = (state_q == S_FINISH);

endmodule
